sdpram_pipe: RTL
================

# sdpram_pipe

Parametrised simple-dual-port RAM with independent write and read ports, byte-enable writes, and a configurable read latency of 1–4 cycles. Reads follow a valid-tagged pipeline. The read-during-write collision policy is selectable at elaboration time. It is the general-purpose storage primitive for FIFOs, line buffers and register-file shadows, replacing fixed single-cycle RAM instances wherever byte writes, deeper output pipelining or defined collision behaviour are needed.

## Interface
Parameters:
- DEPTH, 16: number of RAM entries; any value ≥ 2, not required to be a power of two.
- WIDTH, 32: data width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8: bits per byte-enable lane.
- RD_LAT, 1: read latency in cycles, legal range 1–4. An out-of-range value is an elaboration error.
- RDW_MODE, READ_FIRST: same-address collision policy, of type rdw_mode_e. Values are READ_FIRST and WRITE_FIRST.
- DEPTH_L2, $clog2(DEPTH): derived address width; do not override.
- NB, WIDTH/BYTE_W: derived number of byte lanes; do not override.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write strobe.
- wr_addr  in  DEPTH_L2  write address.
- wr_be  in  NB  byte enables; lane i covers wr_data[i*BYTE_W +: BYTE_W].
- wr_data  in  WIDTH  write data.
- rd_valid  in  1  read request.
- rd_addr  in  DEPTH_L2  read address.
- rd_data_valid  out  1  read data valid; pulses RD_LAT cycles after rd_valid.
- rd_data  out  WIDTH  read data; qualified by rd_data_valid.

## Operation
Write port:
- A write occurs when wr_valid=1 and wr_addr<DEPTH.
- Only lanes with wr_be[i]=1 are updated.
- wr_be=0 with wr_valid=1 is a legal no-op.

Read port:
- When rd_valid=1, the array is sampled at rd_addr on that edge.
- The sampled word is carried through RD_LAT−1 further register stages, each tagged with a valid bit.
- Data in flight is never modified by later writes.

Out-of-range addresses (addr ≥ DEPTH, possible only when DEPTH is not a power of two):
- Writes are dropped.
- Reads complete normally with rd_data=0.

Collision (wr_valid, rd_valid, same in-range address, same edge):
- READ_FIRST: rd_data returns the old word.
- WRITE_FIRST: rd_data returns the merged word. Lanes with wr_be=1 come from wr_data; the rest are the old word.

When rd_valid=0, the pipeline stage valid bit clears. rd_data holds its last value and is don't-care for checking while rd_data_valid=0.

Reset:
- Clears all pipeline valid bits and all data stages to 0.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: rd_data_valid=0, rd_data=0.
- Read latency: rd_valid sampled at edge N gives rd_data_valid=1 and rd_data valid after edge N+RD_LAT−1, i.e. visible for one cycle starting RD_LAT cycles after the request cycle.
- Throughput: one read and one write per cycle, with no stalls and no backpressure.
- Back-to-back reads produce back-to-back rd_data_valid pulses, in order.
- A write at edge N is visible to a different-address read sampled at edge N+1 or later. Same-edge behaviour follows RDW_MODE.
- Reset asserted mid-operation: all in-flight reads are discarded asynchronously. No rd_data_valid pulse is produced for requests issued before reset deassertion.
- The first request is accepted at the first rising edge with rst=0.

## Structure
- Package sdpram_pkg holds:
  - typedef enum rdw_mode_e {READ_FIRST, WRITE_FIRST};
  - localparam RD_LAT_MAX=4.
- Sub-module valid_pipe:
  - parameters WIDTH and STAGES (STAGES may be 0, meaning pass-through);
  - ports clk, rst, in_valid, in_data, out_valid, out_data;
  - async-reset registers.
  - Instantiated with STAGES=RD_LAT−1 after the array read register.
- Array: unreset reg array sized DEPTH, with a per-lane write loop, written so tools infer block RAM.
- Collision merge logic sits before the first read register.

## Test plan
- Basic: write 0xDEADBEEF to addr 3 (wr_be=0xF); read addr 3 with RD_LAT=1,2,4 → rd_data=0xDEADBEEF with rd_data_valid exactly 1, 2 and 4 cycles after the request, respectively.
- Byte enables: write 0x11223344 to addr 5, then 0xAABBCCDD with wr_be=0b0101; read addr 5 → 0x11BB33DD.
- Collision: preload addr 7=0x0; same cycle write 0xFFFF0000 (be=0xC) and read addr 7 → READ_FIRST returns 0x00000000; WRITE_FIRST returns 0xFFFF0000.
- Streaming: RD_LAT=3, read addrs 0..15 on consecutive cycles after writing addr i=i*3 → 16 consecutive rd_data_valid pulses returning 0,3,…,45 in order.
- Out-of-range: DEPTH=12, write 0x55 to addr 13, then read addr 13 → rd_data=0 with rd_data_valid=1; addr 12 likewise returns 0.
- Reset mid-flight: RD_LAT=4, issue reads on 2 cycles, assert rst 1 cycle later → rd_data_valid stays 0 and rd_data=0. A read after deassert returns the previously written data, showing the array was not reset.

Source files
------------

// File: rtl/sdpram_pkg.sv
// Shared types and limits for the simple-dual-port RAM with pipelined read.
package sdpram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_e;

    localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/sdpram_pipe_if.sv
// Write/read port bundle of sdpram_pipe; master issues requests, slave is the RAM.
interface sdpram_pipe_if #(
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NB    = 4
);
    logic             wr_valid;
    logic [AW-1:0]    wr_addr;
    logic [NB-1:0]    wr_be;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic [AW-1:0]    rd_addr;
    logic             rd_data_valid;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
        input  rd_data_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
        output rd_data_valid, rd_data
    );
endinterface

// File: rtl/sdpram_pipe_valid_pipe.sv
// Valid-tagged delay line; data only advances with its valid bit, STAGES=0 is a wire.
module valid_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_regs
            logic [STAGES-1:0] v;
            logic [WIDTH-1:0]  d [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v <= '0;
                    for (int unsigned i = 0; i < STAGES; i++) d[i] <= '0;
                end else begin
                    v[0] <= in_valid;
                    if (in_valid) d[0] <= in_data;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        v[i] <= v[i-1];
                        if (v[i-1]) d[i] <= d[i-1];
                    end
                end
            end

            assign out_valid = v[STAGES-1];
            assign out_data  = d[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sdpram_pipe.sv
// Simple-dual-port RAM: byte-enable writes, 1..4 cycle valid-tagged reads,
// elaboration-time read-during-write policy.
module sdpram_pipe
    import sdpram_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter rdw_mode_e   RDW_MODE = READ_FIRST,
    parameter int unsigned DEPTH_L2 = $clog2(DEPTH),
    parameter int unsigned NB       = WIDTH / BYTE_W
) (
    input  logic          clk,
    input  logic          rst,
    sdpram_pipe_if.slave  bus
);

    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("sdpram_pipe: RD_LAT must be in 1..%0d", RD_LAT_MAX);
        end
        if (WIDTH % BYTE_W != 0) begin : g_bad_width
            $error("sdpram_pipe: WIDTH must be a multiple of BYTE_W");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_hit_c;
    logic             rd_hit_c;
    logic             collide_c;
    logic [WIDTH-1:0] old_word_c;
    logic [WIDTH-1:0] rd_word_c;

    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    assign wr_hit_c  = bus.wr_valid && (32'(bus.wr_addr) < DEPTH);
    assign rd_hit_c  = 32'(bus.rd_addr) < DEPTH;
    assign collide_c = wr_hit_c && bus.rd_valid && (bus.wr_addr == bus.rd_addr);

    // Byte-lane write; array left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_hit_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.wr_be[i])
                    mem[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Collision merge ahead of the read register: WRITE_FIRST forwards enabled lanes.
    always_comb begin
        old_word_c = '0;
        if (rd_hit_c) old_word_c = mem[bus.rd_addr];
        rd_word_c = old_word_c;
        if (collide_c && (RDW_MODE == WRITE_FIRST)) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.wr_be[i])
                    rd_word_c[i*BYTE_W +: BYTE_W] = bus.wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else begin
            s0_valid <= bus.rd_valid;
            if (bus.rd_valid) s0_data <= rd_word_c;
        end
    end

    valid_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (RD_LAT - 1)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_valid),
        .in_data   (s0_data),
        .out_valid (bus.rd_data_valid),
        .out_data  (bus.rd_data)
    );

endmodule
